// File: rtl/regfile_seq_pkg.sv
// Shared types and encodings for the register-file sequencer: FSM states,
// register-file address-mux selects and default widths.
package regfile_seq_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_ADDR_BITS = 5;

   localparam logic [1:0] SEL_RS = 2'd0;
   localparam logic [1:0] SEL_RT = 2'd1;
   localparam logic [1:0] SEL_RD = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_A,
      S_RD_B,
      S_OPS,
      S_WAIT_WB,
      S_WR_SETUP,
      S_WR_PULSE
   } state_t;

endpackage

// File: rtl/regfile_sequencer_operand_latch.sv
// WIDTH-wide holding register with load enable, a force-to-zero option on load
// and asynchronous clear.
module operand_latch #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             zero,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (load)
         q <= zero ? '0 : d;
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Drives a single-ported register file through its 4:1 address mux: reads rs and
// rt into operand latches, hands them off via valid/ack, then writes the result to rd.
module regfile_sequencer
   import regfile_seq_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ADDR_BITS = DEF_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 ready,
   input  logic [ADDR_BITS-1:0] rs,
   input  logic [ADDR_BITS-1:0] rt,
   input  logic [ADDR_BITS-1:0] rd,
   output logic [WIDTH-1:0]     op_a,
   output logic [WIDTH-1:0]     op_b,
   output logic                 ops_valid,
   input  logic                 ops_ack,
   input  logic                 wb_valid,
   input  logic                 wb_en,
   input  logic [WIDTH-1:0]     wb_data,
   output logic [1:0]           reg_sel,
   output logic [ADDR_BITS-1:0] reg_src0,
   output logic [ADDR_BITS-1:0] reg_src1,
   output logic [ADDR_BITS-1:0] reg_src2,
   output logic [ADDR_BITS-1:0] reg_src3,
   output logic                 rf_n_oe,
   output logic                 rf_n_we,
   output logic [WIDTH-1:0]     rf_in_data,
   input  logic [WIDTH-1:0]     rf_out_data
);

   state_t state, state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:     if (start) state_next = S_RD_A;
         S_RD_A:     state_next = S_RD_B;
         S_RD_B:     state_next = S_OPS;
         S_OPS:      if (ops_ack) state_next = S_WAIT_WB;
         S_WAIT_WB:
            if (wb_valid)
               state_next = (wb_en && (reg_src2 != '0)) ? S_WR_SETUP : S_IDLE;
         S_WR_SETUP: state_next = S_WR_PULSE;
         S_WR_PULSE: state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   // Outputs are pure decodes of the state register, so an async reset clears
   // RF_N_WE immediately, even mid-pulse.
   always_comb begin
      ready     = 1'b0;
      ops_valid = 1'b0;
      rf_n_oe   = 1'b1;
      rf_n_we   = 1'b1;
      reg_sel   = SEL_RS;
      case (state)
         S_IDLE:     ready = 1'b1;
         S_RD_A:     begin reg_sel = SEL_RS; rf_n_oe = 1'b0; end
         S_RD_B:     begin reg_sel = SEL_RT; rf_n_oe = 1'b0; end
         S_OPS:      ops_valid = 1'b1;
         S_WR_SETUP: reg_sel = SEL_RD;
         S_WR_PULSE: begin reg_sel = SEL_RD; rf_n_we = 1'b0; end
         default:    ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_src0 <= '0;
         reg_src1 <= '0;
         reg_src2 <= '0;
      end else if (state == S_IDLE && start) begin
         reg_src0 <= rs;
         reg_src1 <= rt;
         reg_src2 <= rd;
      end
   end

   assign reg_src3 = '0;

   // Register 0 reads as zero regardless of what the SRAM returns.
   operand_latch #(.WIDTH(WIDTH)) u_op_a (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (state == S_RD_A),
      .zero  (reg_src0 == '0),
      .d     (rf_out_data),
      .q     (op_a)
   );

   operand_latch #(.WIDTH(WIDTH)) u_op_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (state == S_RD_B),
      .zero  (reg_src1 == '0),
      .d     (rf_out_data),
      .q     (op_b)
   );

   operand_latch #(.WIDTH(WIDTH)) u_wb_data (
      .clk   (clk),
      .rst_n (rst_n),
      .load  ((state == S_WAIT_WB) && wb_valid),
      .zero  (1'b0),
      .d     (wb_data),
      .q     (rf_in_data)
   );

   a_no_oe_we_overlap: assert property (@(posedge clk) disable iff (!rst_n)
      (rf_n_we || rf_n_oe));
   a_we_targets_rd: assert property (@(posedge clk) disable iff (!rst_n)
      (!rf_n_we |-> (reg_sel == SEL_RD)));

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with an SRAM model, an instruction-level
// golden register array and a per-cycle compare process.
module tb_regfile_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, ready;
   logic [4:0]  rs, rt, rd;
   logic [31:0] op_a, op_b;
   logic        ops_valid, ops_ack;
   logic        wb_valid, wb_en;
   logic [31:0] wb_data;
   logic [1:0]  reg_sel;
   logic [4:0]  reg_src0, reg_src1, reg_src2, reg_src3;
   logic        rf_n_oe, rf_n_we;
   logic [31:0] rf_in_data, rf_out_data;

   int vectors = 0;
   int miscompares = 0;
   int we_low_cnt = 0;

   logic [31:0] gold [32];
   logic [31:0] mem  [32];
   bit          loaded = 1'b0;
   logic [4:0]  mux_addr;

   logic [31:0] exp_a, exp_b, exp_wdata;
   logic [4:0]  exp_rs, exp_rt, exp_rd;
   logic [31:0] ga, gb;

   regfile_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
      .rs(rs), .rt(rt), .rd(rd), .op_a(op_a), .op_b(op_b),
      .ops_valid(ops_valid), .ops_ack(ops_ack),
      .wb_valid(wb_valid), .wb_en(wb_en), .wb_data(wb_data),
      .reg_sel(reg_sel), .reg_src0(reg_src0), .reg_src1(reg_src1),
      .reg_src2(reg_src2), .reg_src3(reg_src3),
      .rf_n_oe(rf_n_oe), .rf_n_we(rf_n_we),
      .rf_in_data(rf_in_data), .rf_out_data(rf_out_data)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'hFFFF_FFFF;
      if (i == 3) return 32'hDEAD_BEEF;
      if (i == 7) return 32'h1234_5678;
      return 32'h1000_0000 + i;
   endfunction

   // Register-file SRAM model: 4:1 address mux, write on the edge ending N_WE low.
   always_comb begin
      mux_addr = reg_src3;
      case (reg_sel)
         2'd0: mux_addr = reg_src0;
         2'd1: mux_addr = reg_src1;
         2'd2: mux_addr = reg_src2;
         default: mux_addr = reg_src3;
      endcase
      rf_out_data = rf_n_oe ? 32'h0 : mem[mux_addr];
   end

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
         loaded <= 1'b1;
      end else if (rst_n && !rf_n_we) begin
         mem[mux_addr] <= rf_in_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // Per-cycle checks against the expectations set when the instruction was issued.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("oe_we_exclusive", {31'd0, rf_n_oe | rf_n_we}, 32'd1);
         chk("src3_zero", {27'd0, reg_src3}, 32'd0);
         if (!rf_n_we) begin
            we_low_cnt++;
            chk("we_sel", {30'd0, reg_sel}, 32'd2);
            chk("we_addr", {27'd0, reg_src2}, {27'd0, exp_rd});
            chk("we_data", rf_in_data, exp_wdata);
         end
         if (ops_valid) begin
            chk("op_a", op_a, exp_a);
            chk("op_b", op_b, exp_b);
         end
         if (!ready) begin
            chk("src0", {27'd0, reg_src0}, {27'd0, exp_rs});
            chk("src1", {27'd0, reg_src1}, {27'd0, exp_rt});
            chk("src2", {27'd0, reg_src2}, {27'd0, exp_rd});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered #1 after a rising edge with the DUT idle; returns likewise.
   task automatic run_instr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                            input logic en, input logic [31:0] data,
                            input int stall, input int wb_delay, input bit abort,
                            output logic [31:0] got_a, output logic [31:0] got_b);
      int we0;
      logic [31:0] held;
      exp_rs = a; exp_rt = b; exp_rd = d;
      exp_a = (a == 5'd0) ? 32'h0 : gold[a];
      exp_b = (b == 5'd0) ? 32'h0 : gold[b];
      exp_wdata = data;
      we0 = we_low_cnt;
      rs = a; rt = b; rd = d; start = 1'b1;
      @(negedge clk); chk("c0_ready", {31'd0, ready}, 32'd1);
      step(); start = 1'b0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
      @(negedge clk);
      chk("c1_sel", {30'd0, reg_sel}, 32'd0);
      chk("c1_oe", {31'd0, rf_n_oe}, 32'd0);
      chk("c1_ready", {31'd0, ready}, 32'd0);
      step(); @(negedge clk);
      chk("c2_sel", {30'd0, reg_sel}, 32'd1);
      chk("c2_oe", {31'd0, rf_n_oe}, 32'd0);
      chk("c2_valid", {31'd0, ops_valid}, 32'd0);
      step(); @(negedge clk);
      chk("c3_valid", {31'd0, ops_valid}, 32'd1);
      chk("c3_oe", {31'd0, rf_n_oe}, 32'd1);
      got_a = op_a; got_b = op_b; held = rf_in_data;
      for (int i = 0; i < stall; i++) begin
         if (i == 0) begin wb_valid = 1'b1; wb_en = 1'b1; wb_data = 32'hDEAD_0000; end
         start = 1'b1; rs = ~a; rt = ~b; rd = ~d;
         step();
         wb_valid = 1'b0; wb_en = 1'b0; start = 1'b0;
         @(negedge clk);
         chk("stall_valid", {31'd0, ops_valid}, 32'd1);
         chk("stall_in_data", rf_in_data, held);
      end
      ops_ack = 1'b1;
      step(); ops_ack = 1'b0;
      @(negedge clk); chk("ack_valid", {31'd0, ops_valid}, 32'd0);
      for (int i = 0; i < wb_delay; i++) begin
         step(); @(negedge clk); chk("wait_ready", {31'd0, ready}, 32'd0);
      end
      wb_valid = 1'b1; wb_en = en; wb_data = data;
      step(); wb_valid = 1'b0; wb_en = 1'b0;
      if (en && d != 5'd0) begin
         @(negedge clk);
         chk("setup_sel", {30'd0, reg_sel}, 32'd2);
         chk("setup_we", {31'd0, rf_n_we}, 32'd1);
         chk("setup_ready", {31'd0, ready}, 32'd0);
         chk("setup_in_data", rf_in_data, data);
         step(); @(negedge clk);
         chk("pulse_we", {31'd0, rf_n_we}, 32'd0);
         if (abort) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rst_we", {31'd0, rf_n_we}, 32'd1);
            chk("rst_ready", {31'd0, ready}, 32'd1);
            chk("rst_valid", {31'd0, ops_valid}, 32'd0);
            chk("rst_sel", {30'd0, reg_sel}, 32'd0);
            chk("rst_src0", {27'd0, reg_src0}, 32'd0);
            chk("rst_op_a", op_a, 32'd0);
            chk("rst_in_data", rf_in_data, 32'd0);
            @(posedge clk); #3 rst_n = 1'b1;
            step();
         end else begin
            step();
            gold[d] = data;
         end
         chk("we_pulses", we_low_cnt - we0, 32'd1);
      end else begin
         @(negedge clk);
         chk("nowr_ready", {31'd0, ready}, 32'd1);
         chk("nowr_we", {31'd0, rf_n_we}, 32'd1);
         step();
         chk("we_pulses", we_low_cnt - we0, 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; rs = '0; rt = '0; rd = '0;
      ops_ack = 1'b0; wb_valid = 1'b0; wb_en = 1'b0; wb_data = '0;
      exp_rs = '0; exp_rt = '0; exp_rd = '0;
      exp_a = '0; exp_b = '0; exp_wdata = '0;
      for (int i = 0; i < 32; i++) gold[i] = init_val(i);

      @(negedge clk); @(negedge clk);
      chk("reset_ready", {31'd0, ready}, 32'd1);
      chk("reset_valid", {31'd0, ops_valid}, 32'd0);
      chk("reset_oe", {31'd0, rf_n_oe}, 32'd1);
      chk("reset_we", {31'd0, rf_n_we}, 32'd1);
      chk("reset_sel", {30'd0, reg_sel}, 32'd0);
      chk("reset_srcs", {12'd0, reg_src0, reg_src1, reg_src2, reg_src3}, 32'd0);
      chk("reset_ops", op_a | op_b, 32'd0);
      chk("reset_in_data", rf_in_data, 32'd0);
      step(); rst_n = 1'b1;
      step();

      run_instr(5'd3, 5'd7, 5'd5, 1'b1, 32'hCAFE_F00D, 0, 0, 1'b0, ga, gb);
      chk("lit_r3", ga, 32'hDEAD_BEEF);
      chk("lit_r7", gb, 32'h1234_5678);

      run_instr(5'd0, 5'd7, 5'd0, 1'b1, 32'h1111_1111, 10, 0, 1'b0, ga, gb);
      chk("lit_r0_zero", ga, 32'h0);

      run_instr(5'd5, 5'd3, 5'd9, 1'b0, 32'h2222_2222, 2, 1, 1'b0, ga, gb);
      chk("lit_r5_written", ga, 32'hCAFE_F00D);
      chk("lit_r3_again", gb, 32'hDEAD_BEEF);

      run_instr(5'd5, 5'd5, 5'd12, 1'b1, 32'h0BAD_F00D, 1, 3, 1'b0, ga, gb);
      run_instr(5'd12, 5'd0, 5'd31, 1'b1, 32'hA5A5_A5A5, 0, 0, 1'b0, ga, gb);
      chk("lit_b2b_r12", ga, 32'h0BAD_F00D);
      chk("lit_rt0_zero", gb, 32'h0);

      run_instr(5'd31, 5'd12, 5'd31, 1'b1, 32'h7777_7777, 0, 0, 1'b1, ga, gb);
      chk("lit_r31", ga, 32'hA5A5_A5A5);

      run_instr(5'd31, 5'd9, 5'd1, 1'b0, 32'h3333_3333, 0, 0, 1'b0, ga, gb);
      chk("lit_r31_not_aborted", ga, 32'hA5A5_A5A5);
      chk("lit_r9_unwritten", gb, 32'h1000_0009);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
